tube_readout: RTL and testbench

TUBE_READOUT -- requirements
Module: tube_readout

---
 rtl/tube_pkg.sv | 13 +
 rtl/tube_fifo.sv | 51 +++++
 rtl/tube_readout.sv | 100 ++++++++++
 tb/tb_tube_readout.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// tube_pkg: shared constants, FSM encoding and word packing for the drift-tube readout.
package tube_pkg;
    localparam int N_TUBES = 32;
    localparam int TIME_W = 8;
    localparam logic [7:0] END_MARK = 8'hFF;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {IDLE, WINDOW, SCAN, MARK} state_t;

    function automatic logic [WORD_W-1:0] pack_word(logic [7:0] hi, logic [7:0] lo);
        return {hi, lo};
    endfunction
endpackage

// File: rtl/tube_fifo.sv
// tube_fifo: synchronous count-based FIFO with a registered, held read port.
module tube_fifo #(
    parameter int DEPTH = 64,
    parameter int W = 16
) (
    input  logic         clk100,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic push, pop;

    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    // Both decisions use the count at the start of the cycle, so a pop never makes room for a same-cycle push.
    assign push = wr_en && !full;
    assign pop = rd_en && !empty;

    always_ff @(posedge clk100) begin
        if (push) mem[wp] <= wr_data;
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            rd_data <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) begin
                rp <= rp + AW'(1);
                rd_data <= mem[rp];
            end
            rd_valid <= pop;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/tube_readout.sv
// tube_readout: trigger-windowed first-hit capture of 32 tube drift times, serialised into a readout FIFO.
module tube_readout
    import tube_pkg::*;
#(
    parameter int WINDOW_CYCLES = 100,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                      clk100,
    input  logic                      rst,
    input  logic                      SCIN_COIN,
    input  logic [N_TUBES-1:0]        hit_stb,
    input  logic [N_TUBES*TIME_W-1:0] tube_time,
    input  logic                      RD_EN,
    output logic [7:0]                OTUBEN,
    output logic [7:0]                OTUBER,
    output logic                      RD_EMPTY,
    output logic                      RD_VALID,
    output logic                      OVF
);
    localparam int CNT_W = $clog2(WINDOW_CYCLES + 1);

    state_t state, next;
    logic [N_TUBES-1:0] flags;
    logic [TIME_W-1:0] times [N_TUBES];
    logic [CNT_W-1:0] win_cnt;
    logic [4:0] scan_idx;
    logic [7:0] event_count;
    logic wr_en, full, win_done;
    logic [WORD_W-1:0] wr_data, rd_data;

    assign win_done = win_cnt == CNT_W'(WINDOW_CYCLES - 1);

    always_ff @(posedge clk100) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        wr_en = 1'b0;
        wr_data = pack_word(8'(scan_idx), times[scan_idx]);
        case (state)
            IDLE: next = SCIN_COIN ? WINDOW : IDLE;
            WINDOW: next = win_done ? SCAN : WINDOW;
            SCAN: begin
                wr_en = flags[scan_idx];
                next = scan_idx == 5'(N_TUBES - 1) ? MARK : SCAN;
            end
            MARK: begin
                wr_en = 1'b1;
                wr_data = pack_word(END_MARK, event_count);
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            flags <= '0;
            win_cnt <= '0;
            scan_idx <= '0;
            event_count <= '0;
            OVF <= 1'b0;
        end else begin
            if (state == IDLE && SCIN_COIN) begin
                flags <= '0;
                win_cnt <= '0;
            end
            if (state == WINDOW) begin
                win_cnt <= win_cnt + CNT_W'(1);
                scan_idx <= '0;
                // First strobe per tube wins; later strobes see the flag already set.
                for (int i = 0; i < N_TUBES; i++)
                    if (hit_stb[i] && !flags[i]) begin
                        flags[i] <= 1'b1;
                        times[i] <= tube_time[i*TIME_W +: TIME_W];
                    end
            end
            if (state == SCAN) scan_idx <= scan_idx + 5'd1;
            if (state == MARK) event_count <= event_count + 8'd1;
            if (wr_en && full) OVF <= 1'b1;
        end
    end

    tube_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
        .clk100(clk100),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(RD_EN),
        .rd_data(rd_data),
        .rd_valid(RD_VALID),
        .empty(RD_EMPTY),
        .full(full)
    );

    assign OTUBEN = rd_data[15:8];
    assign OTUBER = rd_data[7:0];
endmodule

// File: tb/tb_tube_readout.sv
// tb_tube_readout: directed scenarios plus random traffic against a cycle-level event/queue reference model.
module tb_tube_readout;
    localparam int W = 100;
    localparam int D = 64;

    logic clk100 = 1'b0;
    logic rst, SCIN_COIN, RD_EN;
    logic [31:0] hit_stb;
    logic [255:0] tube_time;
    logic [7:0] OTUBEN, OTUBER;
    logic RD_EMPTY, RD_VALID, OVF;

    always #5 clk100 = ~clk100;

    tube_readout #(.WINDOW_CYCLES(W), .FIFO_DEPTH(D)) dut (
        .clk100(clk100),
        .rst(rst),
        .SCIN_COIN(SCIN_COIN),
        .hit_stb(hit_stb),
        .tube_time(tube_time),
        .RD_EN(RD_EN),
        .OTUBEN(OTUBEN),
        .OTUBER(OTUBER),
        .RD_EMPTY(RD_EMPTY),
        .RD_VALID(RD_VALID),
        .OVF(OVF)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] mq[$];
    logic m_ovf = 1'b0, m_valid = 1'b0;
    logic [15:0] m_out = '0;
    logic [7:0] m_evc = '0;
    int ev_pos = 0;
    logic [31:0] m_flag = '0;
    logic [7:0] m_time [32];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ev_pos: 0 idle, 1..W window cycles, W+1..W+32 tube scan, W+33 end marker.
    task automatic cycle();
        int n;
        bit wr;
        logic [15:0] w;
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_valid = 0;
            m_out = 0;
            m_evc = 0;
            ev_pos = 0;
            m_flag = 0;
        end else begin
            n = mq.size();
            wr = 0;
            w = 0;
            m_valid = RD_EN && n > 0;
            if (m_valid) m_out = mq.pop_front();
            if (ev_pos == 0) begin
                if (SCIN_COIN) begin
                    m_flag = 0;
                    ev_pos = 1;
                end
            end else begin
                if (ev_pos <= W) begin
                    for (int i = 0; i < 32; i++)
                        if (hit_stb[i] && !m_flag[i]) begin
                            m_flag[i] = 1;
                            m_time[i] = tube_time[8*i +: 8];
                        end
                end else if (ev_pos <= W + 32) begin
                    wr = m_flag[ev_pos-W-1];
                    w = {8'(ev_pos - W - 1), m_time[ev_pos-W-1]};
                end else begin
                    wr = 1;
                    w = {8'hFF, m_evc};
                    m_evc++;
                end
                ev_pos = (ev_pos == W + 33) ? 0 : ev_pos + 1;
            end
            if (wr) begin
                if (n < D) mq.push_back(w);
                else m_ovf = 1;
            end
        end
        @(posedge clk100);
        #1;
        check("valid", 32'(RD_VALID), 32'(m_valid));
        check("data", 32'({OTUBEN, OTUBER}), 32'(m_out));
        check("empty", 32'(RD_EMPTY), 32'(mq.size() == 0));
        check("ovf", 32'(OVF), 32'(m_ovf));
        SCIN_COIN = 0;
        hit_stb = 0;
        RD_EN = 0;
        rst = 0;
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic trig();
        SCIN_COIN = 1;
        cycle();
    endtask

    task automatic hit(int t, logic [7:0] v);
        hit_stb[t] = 1;
        tube_time[8*t +: 8] = v;
    endtask

    task automatic finish_event();
        while (ev_pos != 0) cycle();
    endtask

    task automatic read_one(output logic [15:0] w);
        RD_EN = 1;
        cycle();
        w = {OTUBEN, OTUBER};
    endtask

    initial begin
        logic [15:0] w, e;
        rst = 1;
        SCIN_COIN = 0;
        RD_EN = 0;
        hit_stb = 0;
        tube_time = 0;
        cycle();
        check("rst_empty", 32'(RD_EMPTY), 1);
        check("rst_valid", 32'(RD_VALID), 0);
        check("rst_out", 32'({OTUBEN, OTUBER}), 0);
        check("rst_ovf", 32'(OVF), 0);

        trig(); idle(10); hit(3, 8'h12); cycle(); idle(20); hit(30, 8'h40); cycle(); finish_event();
        read_one(w); check("e1_w0", 32'(w), 32'h0312);
        read_one(w); check("e1_w1", 32'(w), 32'h1E40);
        read_one(w); check("e1_mark", 32'(w), 32'hFF00);
        check("e1_empty", 32'(RD_EMPTY), 1);

        trig(); hit(5, 8'h10); cycle(); idle(5); hit(5, 8'h20); cycle(); finish_event();
        read_one(w); check("dup_w0", 32'(w), 32'h0510);
        read_one(w); check("dup_mark", 32'(w), 32'hFF01);
        check("dup_empty", 32'(RD_EMPTY), 1);

        trig(); idle(99); hit(7, 8'h77); cycle(); hit(8, 8'h88); cycle(); finish_event();
        read_one(w); check("edge_w0", 32'(w), 32'h0777);
        read_one(w); check("edge_mark", 32'(w), 32'hFF02);
        check("edge_empty", 32'(RD_EMPTY), 1);

        trig(); hit(1, 8'h11); cycle(); idle(W - 1 + 5);
        SCIN_COIN = 1; cycle();
        while (ev_pos != W + 33) cycle();
        SCIN_COIN = 1; cycle();
        idle(W + 40);
        read_one(w); check("retrig_w0", 32'(w), 32'h0111);
        read_one(w); check("retrig_mark", 32'(w), 32'hFF03);
        check("retrig_empty", 32'(RD_EMPTY), 1);
        read_one(w);
        check("rd_empty_valid", 32'(RD_VALID), 0);
        check("rd_empty_hold", 32'(w), 32'hFF03);

        for (int ev = 0; ev < 3; ev++) begin
            trig();
            for (int t = 0; t < 32; t++) hit(t, 8'(t * 3 + ev));
            cycle();
            finish_event();
        end
        check("full_ovf", 32'(OVF), 1);
        for (int k = 0; k < 64; k++) begin
            read_one(w);
            e = k < 32 ? {8'(k), 8'(k * 3)} : k == 32 ? 16'hFF04 : {8'(k - 33), 8'((k - 33) * 3 + 1)};
            check("full_rd", 32'(w), 32'(e));
        end
        check("full_drained", 32'(RD_EMPTY), 1);
        check("ovf_sticky", 32'(OVF), 1);

        trig(); hit(2, 8'h22); cycle(); finish_event();
        trig(); idle(50); rst = 1; cycle();
        check("midrst_empty", 32'(RD_EMPTY), 1);
        check("midrst_ovf", 32'(OVF), 0);
        idle(W + 40);
        check("midrst_nomark", 32'(RD_EMPTY), 1);
        trig(); hit(9, 8'h99); cycle(); finish_event();
        read_one(w); check("midrst_w0", 32'(w), 32'h0999);
        read_one(w); check("midrst_mark", 32'(w), 32'hFF00);

        for (int c = 0; c < 8000; c++) begin
            hit_stb = $urandom & $urandom & $urandom & $urandom & $urandom;
            for (int j = 0; j < 8; j++) tube_time[32*j +: 32] = $urandom;
            RD_EN = $urandom_range(0, 4) == 0;
            SCIN_COIN = $urandom_range(0, 30) == 0;
            rst = $urandom_range(0, 2500) == 0;
            cycle();
        end
        for (int c = 0; c < 300; c++) begin
            RD_EN = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
